// File: rtl/sipo_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_frame_ctrl
//  Description : Framed serial-in / parallel-out receiver. Collects WIDTH
//                qualified bits (first bit lands in the MSB) into a shift
//                register and hands each completed word to a single output
//                holding register guarded by a valid/ready handshake.
//                Reception never stalls: a word completing while the holding
//                register is still occupied is dropped and flagged as overrun.
//                A frame_start inside a frame restarts it and pulses resync.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_frame_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       serial_in,
   input  logic                       bit_valid,
   input  logic                       frame_start,
   input  logic                       out_ready,
   input  logic                       overrun_clr,
   output logic [WIDTH-1:0]           parallel_out,
   output logic                       out_valid,
   output logic                       busy,
   output logic [$clog2(WIDTH+1)-1:0] bit_count,
   output logic                       overrun,
   output logic                       resync
);

   localparam int CNT_W = $clog2(WIDTH+1);

   // Count value held just before the final bit of a frame arrives.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   shift_reg;
   logic [WIDTH-1:0]   shift_nxt;
   logic [WIDTH-1:0]   frame_word;
   logic [WIDTH-1:0]   first_word;
   logic [CNT_W-1:0]   count_nxt;
   logic               frame_done;
   logic               restart;
   logic               load_word;
   logic               drop_word;

   // Shift register contents after taking serial_in as the next bit, and
   // after taking serial_in as bit 0 of a fresh frame.
   assign frame_word = {shift_reg[WIDTH-2:0], serial_in};
   assign first_word = {{(WIDTH-1){1'b0}}, serial_in};

   // A completed word goes to the holding register when it is empty or is
   // being emptied on this very edge; otherwise it is lost.
   assign load_word = frame_done & (~out_valid | out_ready);
   assign drop_word = frame_done & out_valid & ~out_ready;

   assign busy = (state == SHIFT);

   // Frame state register: state, shift register and bit counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_count <= '0;
      end else begin
         state     <= state_nxt;
         shift_reg <= shift_nxt;
         bit_count <= count_nxt;
      end
   end

   // Next-state logic: start, shift, restart and completion decisions.
   always_comb begin
      state_nxt  = state;
      shift_nxt  = shift_reg;
      count_nxt  = bit_count;
      frame_done = 1'b0;
      restart    = 1'b0;
      case (state)
         IDLE: begin
            // Bits outside a frame are ignored until frame_start marks bit 0.
            if (bit_valid && frame_start) begin
               shift_nxt = first_word;
               count_nxt = ONE_CNT;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_valid) begin
               if (frame_start) begin
                  // Restart wins even on the bit that would complete a frame.
                  shift_nxt = first_word;
                  count_nxt = ONE_CNT;
                  restart   = 1'b1;
               end else if (bit_count == LAST_CNT) begin
                  frame_done = 1'b1;
                  shift_nxt  = frame_word;
                  count_nxt  = '0;
                  state_nxt  = IDLE;
               end else begin
                  shift_nxt = frame_word;
                  count_nxt = bit_count + ONE_CNT;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output holding register and its valid/ready handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         parallel_out <= '0;
         out_valid    <= 1'b0;
      end else if (load_word) begin
         parallel_out <= frame_word;
         out_valid    <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid    <= 1'b0;
      end
   end

   // Sticky overrun flag; a new drop outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (drop_word) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

   // One-cycle resync pulse following a mid-frame restart.
   always_ff @(posedge clk) begin
      if (reset) begin
         resync <= 1'b0;
      end else begin
         resync <= restart;
      end
   end

endmodule
`default_nettype wire

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, frame length in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset is synchronous and active-high.
REQ-004 SHALL have port serial_in  input  1  serial data bit, sampled only when bit_valid=1.
REQ-005 SHALL have port bit_valid  input  1  qualifies serial_in for one cycle.
REQ-006 SHALL have port frame_start  input  1  marks the current valid bit as bit 0 of a frame; ignored when bit_valid=0.
REQ-007 SHALL have port out_ready  input  1  consumer accepts parallel_out when out_valid=1.
REQ-008 SHALL have port overrun_clr  input  1  clears the overrun flag.
REQ-009 SHALL have port parallel_out  output  WIDTH  completed frame word, MSB = first bit received.
REQ-010 SHALL have port out_valid  output  1  parallel_out holds an unaccepted word.
REQ-011 SHALL have port busy  output  1  high while in SHIFT.
REQ-012 SHALL have port bit_count  output  $clog2(WIDTH+1)  bits collected in the current frame.
REQ-013 SHALL have port overrun  output  1  sticky: a completed word was dropped.
REQ-014 SHALL have port resync  output  1  one-cycle pulse: frame restarted before completion.

Function
REQ-015 SHALL implement FSM with states IDLE and SHIFT; internal WIDTH-bit shift register plus one output holding register (parallel_out).
REQ-016 IDLE: bit_valid&frame_start -> shift in bit, bit_count=1, go SHIFT; bit_valid without frame_start ignored.
REQ-017 SHIFT: each bit_valid cycle SHALL shift left, serial_in into LSB, bit_count+1; cycles with bit_valid=0 hold all state.
REQ-018 On the edge sampling bit WIDTH: frame completes, word {shift[WIDTH-2:0],serial_in} offered to holding register, bit_count->0, state->IDLE.
REQ-019 Completion latency SHALL be zero extra cycles: out_valid=1 and parallel_out valid immediately after the edge sampling the last bit.
REQ-020 Handshake: word transfers on any edge with out_valid&out_ready; out_valid then drops unless a new word loads the same edge.
REQ-021 parallel_out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Completion with out_valid=0, or out_valid&out_ready same edge: new word loads, out_valid=1.
REQ-023 Completion with out_valid=1 and out_ready=0: new word dropped, held word unchanged, overrun set.
REQ-024 Shifting SHALL continue while output is held (double buffering); backpressure never stalls reception.
REQ-025 SHIFT with bit_valid&frame_start: current partial frame discarded, bit taken as bit 0, bit_count=1, resync pulses one cycle.
REQ-026 frame_start on the bit that would complete a frame SHALL take REQ-025 (restart), not completion.
REQ-027 overrun_clr clears overrun; if set and clear coincide, set wins.
REQ-028 busy=1 exactly when state=SHIFT.

Reset
REQ-029 reset SHALL take priority over all inputs, including mid-frame and with out_valid=1.
REQ-030 After reset: state IDLE, shift register 0, parallel_out 0, out_valid 0, busy 0, bit_count 0, overrun 0, resync 0; pending word discarded.

Verification (WIDTH=8)
REQ-031 Send 0xA5 MSB-first, bit_valid every cycle, frame_start on bit 0, out_ready=1 -> out_valid=1 one cycle only, parallel_out=0xA5, bit_count 1..7 then 0.
REQ-032 Send 0x3C with bit_valid=0 gaps of 1-3 cycles between bits -> parallel_out=0x3C, state/bit_count frozen during gaps.
REQ-033 out_ready=0; send 0x11 then 0x22 -> parallel_out stays 0x11, overrun=1 after second completion; out_ready=1 -> out_valid drops; overrun_clr -> overrun=0.
REQ-034 out_ready=0; send 0x11; raise out_ready exactly on the edge 0x22 completes -> no overrun, parallel_out=0x22, out_valid=1.
REQ-035 Send 5 bits, then frame_start with 0x96 -> resync single pulse, parallel_out=0x96, no word from partial frame.
REQ-036 reset asserted after 4 bits and while out_valid=1 -> all outputs 0 next cycle; following frame 0xF0 received correctly.
